fetch_pc_sequencer: RTL

Fetch-side controller that owns the program counter and sequences instruction-memory requests for the decode stage. It issues one memory request at a time and buffers returned instructions in a 2-entry queue. It presents instructions downstream with a valid/ready handshake. On a jump it redirects the PC, flushes the queue and discards any in-flight stale response.

---
 rtl/fetch_pc_sequencer_pkg.sv | 22 ++
 rtl/fetch_pc_sequencer_if.sv | 41 ++++
 rtl/fetch_pc_sequencer_buffer.sv | 72 +++++++
 rtl/fetch_pc_sequencer.sv | 156 +++++++++++++++
 4 files changed

// File: rtl/fetch_pc_sequencer_pkg.sv
// Shared definitions for the fetch PC sequencer: sequencer state, datapath
// width, PC increment and the default reset PC.
package fetch_pkg;

  localparam int          XLEN             = 32;
  localparam logic [31:0] PC_STEP          = 32'd4;
  localparam logic [31:0] DEFAULT_RESET_PC = 32'h8000_0000;

  // IDLE: nothing in flight, WAIT: one granted request pending,
  // DROP: one stale (pre-jump) request pending whose data must be discarded.
  typedef enum logic [1:0] {
    IDLE = 2'd0,
    WAIT = 2'd1,
    DROP = 2'd2
  } fetch_state_e;

  // Sequential fetch address; wraps modulo 2^32.
  function automatic logic [XLEN-1:0] next_pc(input logic [XLEN-1:0] pc);
    return pc + PC_STEP;
  endfunction

endpackage

// File: rtl/fetch_pc_sequencer_if.sv
// Bundle of the redirect, instruction-memory and decode handshake signals.
// The master modport is the sequencer's view. pc_o exists only when
// FETCH_TRACE_EN is defined.
interface fetch_pc_sequencer_if;
  import fetch_pkg::*;

  logic            jump_flag_i;
  logic [XLEN-1:0] jump_addr_i;
  logic            mem_req_o;
  logic [XLEN-1:0] mem_addr_o;
  logic            mem_gnt_i;
  logic            mem_rvalid_i;
  logic [XLEN-1:0] mem_rdata_i;
  logic            valid_o;
  logic            ready_i;
  logic [XLEN-1:0] inst_o;
`ifdef FETCH_TRACE_EN
  logic [XLEN-1:0] pc_o;

  modport master (
    input  jump_flag_i, jump_addr_i, mem_gnt_i, mem_rvalid_i, mem_rdata_i, ready_i,
    output mem_req_o, mem_addr_o, valid_o, inst_o, pc_o
  );

  modport slave (
    output jump_flag_i, jump_addr_i, mem_gnt_i, mem_rvalid_i, mem_rdata_i, ready_i,
    input  mem_req_o, mem_addr_o, valid_o, inst_o, pc_o
  );
`else
  modport master (
    input  jump_flag_i, jump_addr_i, mem_gnt_i, mem_rvalid_i, mem_rdata_i, ready_i,
    output mem_req_o, mem_addr_o, valid_o, inst_o
  );

  modport slave (
    output jump_flag_i, jump_addr_i, mem_gnt_i, mem_rvalid_i, mem_rdata_i, ready_i,
    input  mem_req_o, mem_addr_o, valid_o, inst_o
  );
`endif

endinterface

// File: rtl/fetch_pc_sequencer_buffer.sv
// fetch_buffer: small power-of-two FIFO holding fetched instructions.
// Synchronous flush has priority over push/pop; a push while full is only
// accepted together with a pop.
module fetch_buffer #(
  parameter int DEPTH = 2,
  parameter int WIDTH = 32
) (
  input  logic                       clk,
  input  logic                       reset_n,
  input  logic                       flush,
  input  logic                       push,
  input  logic                       pop,
  input  logic [WIDTH-1:0]           wdata,
  output logic [WIDTH-1:0]           rdata,
  output logic [$clog2(DEPTH):0]     count,
  output logic                       empty,
  output logic                       full
);

  localparam int                PTR_W   = $clog2(DEPTH);
  localparam logic [PTR_W:0]    DEPTH_C = (PTR_W+1)'(DEPTH);

  logic [WIDTH-1:0] mem_r [DEPTH];
  logic [PTR_W-1:0] rd_ptr_r;
  logic [PTR_W-1:0] wr_ptr_r;
  logic [PTR_W:0]   count_r;
  logic             do_push_s;
  logic             do_pop_s;

  // Qualify push/pop against the current fill level and drive status flags.
  always_comb begin
    empty     = (count_r == {(PTR_W+1){1'b0}});
    full      = (count_r == DEPTH_C);
    do_pop_s  = pop && !empty;
    do_push_s = push && (!full || do_pop_s);
    count     = count_r;
    rdata     = mem_r[rd_ptr_r];
  end

  // Entry storage, written at the tail on every accepted push.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      for (int i = 0; i < DEPTH; i++) begin
        mem_r[i] <= '0;
      end
    end else if (do_push_s && !flush) begin
      mem_r[wr_ptr_r] <= wdata;
    end
  end

  // Pointers wrap naturally because DEPTH is a power of two.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      rd_ptr_r <= '0;
      wr_ptr_r <= '0;
      count_r  <= '0;
    end else if (flush) begin
      rd_ptr_r <= '0;
      wr_ptr_r <= '0;
      count_r  <= '0;
    end else begin
      if (do_push_s) begin
        wr_ptr_r <= wr_ptr_r + {{(PTR_W-1){1'b0}}, 1'b1};
      end
      if (do_pop_s) begin
        rd_ptr_r <= rd_ptr_r + {{(PTR_W-1){1'b0}}, 1'b1};
      end
      count_r <= count_r + {{PTR_W{1'b0}}, do_push_s} - {{PTR_W{1'b0}}, do_pop_s};
    end
  end

endmodule

// File: rtl/fetch_pc_sequencer.sv
// fetch_pc_sequencer: owns the PC, issues one instruction-memory request at a
// time and buffers responses for decode. A jump redirects the PC, flushes the
// buffer and marks any in-flight response stale.
// Optional feature macro: FETCH_TRACE_EN (adds pc_o and stores the PC with
// each buffered instruction).
module fetch_pc_sequencer
  import fetch_pkg::*;
#(
  parameter logic [31:0] RESET_PC  = DEFAULT_RESET_PC,
  parameter int          BUF_DEPTH = 2
) (
  input logic                 clk,
  input logic                 reset_n,
  fetch_pc_sequencer_if.master bus
);

  localparam int               CNT_W   = $clog2(BUF_DEPTH) + 1;
  localparam logic [CNT_W:0]   DEPTH_C = (CNT_W+1)'(BUF_DEPTH);
`ifdef FETCH_TRACE_EN
  localparam int               ENTRY_W = 2 * XLEN;
`else
  localparam int               ENTRY_W = XLEN;
`endif

  fetch_state_e     state_r;
  logic [XLEN-1:0]  pc_r;
`ifdef FETCH_TRACE_EN
  logic [XLEN-1:0]  req_pc_r;
`endif

  logic               jump_s;
  logic               rsp_s;
  logic               push_s;
  logic               pop_s;
  logic               valid_s;
  logic               slot_free_s;
  logic               req_s;
  logic               gnt_s;
  logic [CNT_W:0]     occ_next_s;
  logic [CNT_W-1:0]   count_s;
  logic               empty_s;
  logic               full_s;
  logic [ENTRY_W-1:0] push_data_s;
  logic [ENTRY_W-1:0] head_s;

  // Request/accept decisions. A new request may only issue when nothing is
  // outstanding, or when the outstanding response lands this very cycle, so
  // there is never more than one request in flight.
  always_comb begin
    jump_s      = bus.jump_flag_i;
    rsp_s       = (state_r == WAIT) && bus.mem_rvalid_i;
    valid_s     = !empty_s && !jump_s;
    pop_s       = valid_s && bus.ready_i;
    push_s      = rsp_s && !jump_s && (!full_s || pop_s);
    occ_next_s  = {1'b0, count_s} + {{CNT_W{1'b0}}, push_s} - {{CNT_W{1'b0}}, pop_s};
    slot_free_s = (state_r == IDLE) || rsp_s;
    req_s       = !jump_s && slot_free_s && (occ_next_s < DEPTH_C);
    gnt_s       = req_s && bus.mem_gnt_i;
`ifdef FETCH_TRACE_EN
    push_data_s = {req_pc_r, bus.mem_rdata_i};
`else
    push_data_s = bus.mem_rdata_i;
`endif
  end

  // Drive the bus; head fields read as zero while the buffer is empty.
  always_comb begin
    bus.mem_req_o  = req_s;
    bus.mem_addr_o = pc_r;
    bus.valid_o    = valid_s;
    if (empty_s) begin
      bus.inst_o = {XLEN{1'b0}};
`ifdef FETCH_TRACE_EN
      bus.pc_o   = {XLEN{1'b0}};
`endif
    end else begin
      bus.inst_o = head_s[XLEN-1:0];
`ifdef FETCH_TRACE_EN
      bus.pc_o   = head_s[ENTRY_W-1:XLEN];
`endif
    end
  end

  // Sequencer FSM: tracks whether a live or stale response is outstanding.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_r <= IDLE;
    end else begin
      case (state_r)
        IDLE: begin
          if (gnt_s) state_r <= WAIT;
          else       state_r <= IDLE;
        end
        WAIT: begin
          if (jump_s) begin
            if (bus.mem_rvalid_i) state_r <= IDLE;
            else                  state_r <= DROP;
          end else if (bus.mem_rvalid_i) begin
            if (gnt_s) state_r <= WAIT;
            else       state_r <= IDLE;
          end else begin
            state_r <= WAIT;
          end
        end
        DROP: begin
          if (bus.mem_rvalid_i) begin
            if (gnt_s) state_r <= WAIT;
            else       state_r <= IDLE;
          end else begin
            state_r <= DROP;
          end
        end
        default: state_r <= IDLE;
      endcase
    end
  end

  // Program counter: redirect on jump, otherwise step on each grant.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      pc_r <= RESET_PC;
    end else if (jump_s) begin
      pc_r <= bus.jump_addr_i;
    end else if (gnt_s) begin
      pc_r <= next_pc(pc_r);
    end
  end

`ifdef FETCH_TRACE_EN
  // Remember the address of the outstanding request for the trace PC.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      req_pc_r <= {XLEN{1'b0}};
    end else if (gnt_s) begin
      req_pc_r <= pc_r;
    end
  end
`endif

  fetch_buffer #(
    .DEPTH (BUF_DEPTH),
    .WIDTH (ENTRY_W)
  ) u_buffer (
    .clk     (clk),
    .reset_n (reset_n),
    .flush   (jump_s),
    .push    (push_s),
    .pop     (pop_s),
    .wdata   (push_data_s),
    .rdata   (head_s),
    .count   (count_s),
    .empty   (empty_s),
    .full    (full_s)
  );

endmodule
